// File: rtl/div_pkg.sv
// Shared types and helpers for the divider's BCD output formatter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Smallest digit count whose decimal range covers 2^(width-1).
  function automatic int bcd_digits(input int width);
    longint p;
    int     d;
    p = 64'sd10;
    d = 32'sd1;
    for (int i = 0; i < 18; i++) begin
      if (p <= (longint'(1) << (width - 1))) begin
        p = p * 64'sd10;
        d = d + 32'sd1;
      end else begin
        p = p;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/div_bcd_formatter_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift {bcd, mag} left.
module dabble_step #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [WIDTH-1:0]    mag_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [WIDTH-1:0]    mag_out
);

  logic [4*DIGITS-1:0] adj_s;

  // Per-nibble correction followed by the single-bit shift.
  always_comb begin
    adj_s = bcd_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_in[4*i +: 4];
      end
    end
    {bcd_out, mag_out} = {adj_s, mag_in} << 1;
  end

endmodule

// File: rtl/div_bcd_formatter.sv
// Converts the divider's signed quotient/remainder to sign + packed BCD,
// one bit per cycle, under a start/busy/done handshake.
module div_bcd_formatter
  import div_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    quo_in,
  input  logic [WIDTH-1:0]    rem_in,
  output logic                busy,
  output logic                done,
  output logic                quo_sign,
  output logic [4*DIGITS-1:0] quo_bcd,
  output logic                rem_sign,
  output logic [4*DIGITS-1:0] rem_bcd
);

  localparam int CW = (CNT_W > $clog2(WIDTH)) ? CNT_W : $clog2(WIDTH);
  localparam int BW = 4 * DIGITS;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qsign_q, qsign_d, rsign_q, rsign_d;
  logic [WIDTH-1:0] qmag_q, qmag_d, rmag_q, rmag_d;
  logic [BW-1:0]   qscr_q, qscr_d, rscr_q, rscr_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            quo_sign_q, quo_sign_d, rem_sign_q, rem_sign_d;
  logic [BW-1:0]   quo_bcd_q, quo_bcd_d, rem_bcd_q, rem_bcd_d;

  logic [BW-1:0]    qstep_bcd_s, rstep_bcd_s;
  logic [WIDTH-1:0] qstep_mag_s, rstep_mag_s;

  dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_quo_step (
    .bcd_in (qscr_q),
    .mag_in (qmag_q),
    .bcd_out(qstep_bcd_s),
    .mag_out(qstep_mag_s)
  );

  dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_rem_step (
    .bcd_in (rscr_q),
    .mag_in (rmag_q),
    .bcd_out(rstep_bcd_s),
    .mag_out(rstep_mag_s)
  );

  // Next-state logic; outputs are loaded on entry to DONE so they appear with done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    qmag_d     = qmag_q;
    rmag_d     = rmag_q;
    qscr_d     = qscr_q;
    rscr_d     = rscr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quo_sign_d = quo_sign_q;
    rem_sign_d = rem_sign_q;
    quo_bcd_d  = quo_bcd_q;
    rem_bcd_d  = rem_bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          qsign_d = quo_in[WIDTH-1];
          rsign_d = rem_in[WIDTH-1];
          // Negating -2^(WIDTH-1) wraps back to 2^(WIDTH-1) as an unsigned value.
          qmag_d  = quo_in[WIDTH-1] ? ({WIDTH{1'b0}} - quo_in) : quo_in;
          rmag_d  = rem_in[WIDTH-1] ? ({WIDTH{1'b0}} - rem_in) : rem_in;
          qscr_d  = {BW{1'b0}};
          rscr_d  = {BW{1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        qscr_d = qstep_bcd_s;
        qmag_d = qstep_mag_s;
        rscr_d = rstep_bcd_s;
        rmag_d = rstep_mag_s;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          quo_bcd_d  = qstep_bcd_s;
          rem_bcd_d  = rstep_bcd_s;
          quo_sign_d = qsign_q;
          rem_sign_d = rsign_q;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      qsign_q    <= 1'b0;
      rsign_q    <= 1'b0;
      qmag_q     <= {WIDTH{1'b0}};
      rmag_q     <= {WIDTH{1'b0}};
      qscr_q     <= {BW{1'b0}};
      rscr_q     <= {BW{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      quo_bcd_q  <= {BW{1'b0}};
      rem_bcd_q  <= {BW{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qsign_q    <= qsign_d;
      rsign_q    <= rsign_d;
      qmag_q     <= qmag_d;
      rmag_q     <= rmag_d;
      qscr_q     <= qscr_d;
      rscr_q     <= rscr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_sign_q <= quo_sign_d;
      rem_sign_q <= rem_sign_d;
      quo_bcd_q  <= quo_bcd_d;
      rem_bcd_q  <= rem_bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quo_sign = quo_sign_q;
  assign quo_bcd  = quo_bcd_q;
  assign rem_sign = rem_sign_q;
  assign rem_bcd  = rem_bcd_q;

endmodule
